// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state type, word-length
// encodings and stop-bit tick counts (in units of 16x baud ticks).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    // LCR word-length select encodings
    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Stop-bit lengths at 16 ticks per bit period
    localparam int unsigned STOP_1_TICKS  = 16;
    localparam int unsigned STOP_15_TICKS = 24;
    localparam int unsigned STOP_2_TICKS  = 32;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Character handshake between the THR/TX FIFO (master) and the
// serializer (slave).
//   DIN       : character to send
//   DIN_VALID : DIN holds a character
//   DIN_READY : serializer accepts a character this cycle
interface uart_tx_serializer_if;

    logic [7:0] DIN;
    logic       DIN_VALID;
    logic       DIN_READY;

    modport master (
        output DIN,
        output DIN_VALID,
        input  DIN_READY
    );

    modport slave (
        input  DIN,
        input  DIN_VALID,
        output DIN_READY
    );

endinterface

// File: rtl/uart_tx_parity.sv
// Parity generator for a 5-8 bit UART character; shared by TX and RX.
//   data   : character (bits at or above the word length are ignored)
//   WLS    : word length select (00=5 .. 11=8)
//   EPS    : even parity select
//   SP     : stick parity (parity bit forced to ~EPS)
//   parity : parity bit to transmit / expect
module uart_tx_parity (
    input  logic [7:0] data,
    input  logic [1:0] WLS,
    input  logic       EPS,
    input  logic       SP,
    output logic       parity
);

    logic [7:0] mask;
    logic       x;

    always_comb begin
        mask = 8'hFF >> (2'd3 - WLS);
        x    = ^(data & mask);
        if (SP)
            parity = ~EPS;
        else if (EPS)
            parity = x;
        else
            parity = ~x;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer (16750 line format). Accepts a character on
// the tx handshake and shifts out start, 5-8 data bits LSB first,
// optional parity and 1/1.5/2 stop bits on SOUT, timed by a 16x baud
// enable.
//   CLK, RST  : clock, asynchronous active-high reset
//   BAUDCE    : 16x baud-rate enable pulse
//   WLS/STB/PE/EPS/SP : line control, latched on acceptance
//   BC        : break control (only with UART_TX_BREAK_EN defined)
//   tx        : DIN / DIN_VALID / DIN_READY handshake (slave)
//   SOUT      : registered serial output, idle high
//   TXDONE    : one-cycle pulse as the last stop bit completes
//   BUSY      : frame in progress
// Build option: `define UART_TX_BREAK_EN to let BC force SOUT low.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BAUDCE,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PE,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    uart_tx_serializer_if.slave tx,
    output logic       SOUT,
    output logic       TXDONE,
    output logic       BUSY
);

    // Last tick index of each bit kind; the 5-bit counter never has to hold
    // the full bit length, so a 2-stop-bit period still fits.
    localparam logic [4:0] BIT_LAST    = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP1_LAST  = 5'(STOP_1_TICKS  * OVERSAMPLE / 16 - 1);
    localparam logic [4:0] STOP15_LAST = 5'(STOP_15_TICKS * OVERSAMPLE / 16 - 1);
    localparam logic [4:0] STOP2_LAST  = 5'(STOP_2_TICKS  * OVERSAMPLE / 16 - 1);

    tx_state_t  state, state_next;
    logic [4:0] tick, bit_last;
    logic [2:0] bit_idx, bit_idx_next;
    logic [7:0] data_q;
    logic [1:0] wls_q;
    logic       stb_q, pe_q, eps_q, sp_q;
    logic       accept, bit_end, last_data, par_bit;
    logic       sout_next, txdone_next;

`ifndef UART_TX_BREAK_EN
    logic unused_bc;
    assign unused_bc = BC;
`endif

    uart_tx_parity u_parity (
        .data   (data_q),
        .WLS    (wls_q),
        .EPS    (eps_q),
        .SP     (sp_q),
        .parity (par_bit)
    );

    always_comb begin
        bit_last = BIT_LAST;
        if (state == STOP) begin
            if (!stb_q)
                bit_last = STOP1_LAST;
            else if (wls_q == WLS_5)
                bit_last = STOP15_LAST;
            else
                bit_last = STOP2_LAST;
        end
    end

    assign accept    = tx.DIN_VALID && (state == IDLE);
    assign bit_end   = BAUDCE && (state != IDLE) && (tick == bit_last);
    assign last_data = (bit_idx == (3'(wls_q) + 3'd4));

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        case (state)
            IDLE: begin
                bit_idx_next = '0;
                if (accept)
                    state_next = START;
            end
            START: if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end) begin
                    if (last_data)
                        state_next = pe_q ? PAR : STOP;
                    else
                        bit_idx_next = bit_idx + 3'd1;
                end
            end
            PAR:  if (bit_end) state_next = STOP;
            STOP: if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs; SOUT is registered from the next state so the line moves
    // exactly one cycle after the BAUDCE that ends a bit.
    always_comb begin
        tx.DIN_READY = (state == IDLE);
        BUSY         = (state != IDLE);
        txdone_next  = (state == STOP) && bit_end;
        case (state_next)
            START:   sout_next = 1'b0;
            DATA:    sout_next = data_q[bit_idx_next];
            PAR:     sout_next = par_bit;
            default: sout_next = 1'b1;
        endcase
    end

    // Datapath: tick/bit counters, latched character and line control
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick    <= '0;
            bit_idx <= '0;
            data_q  <= '0;
            wls_q   <= '0;
            stb_q   <= 1'b0;
            pe_q    <= 1'b0;
            eps_q   <= 1'b0;
            sp_q    <= 1'b0;
            SOUT    <= 1'b1;
            TXDONE  <= 1'b0;
        end else begin
            bit_idx <= bit_idx_next;
            if (state == IDLE || bit_end)
                tick <= '0;
            else if (BAUDCE)
                tick <= tick + 5'd1;
            if (accept) begin
                data_q <= tx.DIN;
                wls_q  <= WLS;
                stb_q  <= STB;
                pe_q   <= PE;
                eps_q  <= EPS;
                sp_q   <= SP;
            end
`ifdef UART_TX_BREAK_EN
            SOUT   <= BC ? 1'b0 : sout_next;
`else
            SOUT   <= sout_next;
`endif
            TXDONE <= txdone_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer. Each character sent pushes
// its expected line runs (level, tick count) to a queue; a monitor
// measures the runs seen on SOUT and compares them at each level change
// and at TXDONE.
module tb_uart_tx_serializer;

    logic       CLK, RST, STB, PE, EPS, SP, BC;
    logic       SOUT, TXDONE, BUSY, BAUDCE;
    logic [1:0] WLS;
    logic       gen_ce, man_ce, baud_en;
    int         baud_div, bcnt;

    uart_tx_serializer_if tx_if ();

    uart_tx_serializer #(.OVERSAMPLE(16)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BAUDCE (BAUDCE),
        .WLS    (WLS),
        .STB    (STB),
        .PE     (PE),
        .EPS    (EPS),
        .SP     (SP),
        .BC     (BC),
        .tx     (tx_if.slave),
        .SOUT   (SOUT),
        .TXDONE (TXDONE),
        .BUSY   (BUSY)
    );

    typedef struct {
        logic lvl;
        int   ticks;
        logic last;
    } run_t;

    run_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0, done_cyc = 0, cur_ticks = 0;
    logic in_frame = 1'b0, cur_lvl = 1'b1, prev_sout = 1'b1, rdy_seen = 1'b0;
    logic mon_en = 1'b1, b2b_chk = 1'b0, accept_ce = 1'b0, sb_push = 1'b1;

    assign BAUDCE = gen_ce | man_ce;

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (baud_en) begin
            if (bcnt >= baud_div - 1) begin
                bcnt   = 0;
                gen_ce = 1'b1;
            end else begin
                bcnt   = bcnt + 1;
                gen_ce = 1'b0;
            end
        end else begin
            bcnt   = 0;
            gen_ce = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic [1:0] w, input logic s,
                              input logic p, input logic e, input logic k);
        logic lv[$];
        int   tk[$];
        int   nb;
        logic x;
        run_t r;
        nb = int'(w) + 5;
        x  = 1'b0;
        lv.push_back(1'b0); tk.push_back(16);
        for (int i = 0; i < nb; i++) begin
            lv.push_back(d[i]); tk.push_back(16);
            x = x ^ d[i];
        end
        if (p) begin
            lv.push_back(k ? ~e : (e ? x : ~x)); tk.push_back(16);
        end
        lv.push_back(1'b1);
        tk.push_back(!s ? 16 : (w == 2'b00 ? 24 : 32));
        r.lvl = lv[0]; r.ticks = tk[0]; r.last = 1'b0;
        for (int i = 1; i < lv.size(); i++) begin
            if (lv[i] == r.lvl) begin
                r.ticks += tk[i];
            end else begin
                exp_q.push_back(r);
                r.lvl = lv[i]; r.ticks = tk[i];
            end
        end
        r.last = 1'b1;
        exp_q.push_back(r);
    endtask

    task automatic close_run(input logic lvl, input int ticks, input logic by_done);
        run_t r;
        check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        r = exp_q.pop_front();
        check("run", {14'd0, by_done, lvl, 16'(ticks)}, {14'd0, r.last, r.lvl, 16'(r.ticks)});
    endtask

    // Line monitor, sampled 1 time unit after the falling clock edge
    always @(negedge CLK) begin
        #1;
        cyc++;
        if (RST) begin
            exp_q.delete();
            in_frame = 1'b0;
        end else if (mon_en) begin
            if (TXDONE) begin
                check("done_in_frame", 32'(in_frame), 32'd1);
                if (in_frame) begin
                    close_run(cur_lvl, cur_ticks, 1'b1);
                    check("frame_ready_low", 32'(rdy_seen), 32'd0);
                    check("done_handshake", {30'd0, tx_if.DIN_READY, BUSY}, 32'd2);
                    in_frame = 1'b0;
                    done_cyc = cyc;
                end
            end else if (!in_frame) begin
                if (prev_sout && !SOUT) begin
                    in_frame  = 1'b1;
                    cur_lvl   = 1'b0;
                    cur_ticks = 0;
                    rdy_seen  = 1'b0;
                    if (b2b_chk) check("b2b_gap", 32'(cyc - done_cyc), 32'd1);
                end
            end else if (SOUT != cur_lvl) begin
                close_run(cur_lvl, cur_ticks, 1'b0);
                cur_lvl   = SOUT;
                cur_ticks = 0;
            end
            if (in_frame) begin
                if (BAUDCE) cur_ticks++;
                if (tx_if.DIN_READY || !BUSY) rdy_seen = 1'b1;
            end
        end
        prev_sout = SOUT;
    end

    task automatic send(input logic [7:0] d, input logic [1:0] w, input logic s,
                        input logic p, input logic e, input logic k);
        logic acc;
        int   n;
        if (sb_push) push_frame(d, w, s, p, e, k);
        @(negedge CLK);
        tx_if.DIN = d; WLS = w; STB = s; PE = p; EPS = e; SP = k;
        tx_if.DIN_VALID = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 6000) begin
            acc = tx_if.DIN_READY;
            if (acc && accept_ce) man_ce = 1'b1;
            @(negedge CLK);
            n++;
        end
        man_ce = 1'b0;
        check("accept", 32'(acc), 32'd1);
        if (!acc) exp_q.delete();
        // Source drops VALID and scribbles over DIN/config mid-frame
        tx_if.DIN_VALID = 1'b0;
        tx_if.DIN = 8'($urandom);
        WLS = 2'($urandom); STB = 1'($urandom); PE = 1'($urandom);
        EPS = 1'($urandom); SP = 1'($urandom);
`ifndef UART_TX_BREAK_EN
        BC = 1'($urandom);
`endif
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        check("idle_timeout", 32'(n < 20000), 32'd1);
        if (n >= 20000) begin
            exp_q.delete();
            in_frame = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic wait_frame_start();
        int n = 0;
        while (!in_frame && n < 5000) begin
            @(negedge CLK); #1;
            n++;
        end
        check("start_timeout", 32'(in_frame), 32'd1);
    endtask

    task automatic wait_ticks(input int t);
        int c = 0;
        for (int n = 0; n < 5000 && c < t; n++) begin
            @(negedge CLK); #1;
            if (BAUDCE) c++;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic s0, changed;
        CLK = 1'b0; RST = 1'b1; man_ce = 1'b0; gen_ce = 1'b0; baud_en = 1'b1;
        baud_div = 4; bcnt = 0;
        tx_if.DIN = '0; tx_if.DIN_VALID = 1'b0;
        WLS = '0; STB = 1'b0; PE = 1'b0; EPS = 1'b0; SP = 1'b0; BC = 1'b0;
        #1;
        check("rst_sout", 32'(SOUT), 32'd1);
        check("rst_ready", 32'(tx_if.DIN_READY), 32'd1);
        check("rst_txdone", 32'(TXDONE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // 8N1 0xA5, 7E1 0x83, 5-bit 1.5 stop, 8-bit 2 stop, stick parity
        send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); wait_idle();
        send(8'h83, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0); wait_idle();
        send(8'h1F, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0); wait_idle();
        send(8'h0F, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0); wait_idle();
        send(8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        EPS = 1'b1;
        wait_idle();

        // Back-to-back with the next character waiting during the frame
        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_frame_start();
        b2b_chk = 1'b1;
        send(8'hAA, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        b2b_chk = 1'b0;

        // BAUDCE stalled mid-frame: line and FSM hold
        send(8'hC3, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_frame_start();
        wait_ticks(40);
        baud_en = 1'b0;
        @(negedge CLK); #1;
        s0 = SOUT; changed = 1'b0;
        repeat (60) begin
            @(negedge CLK); #1;
            if (SOUT !== s0) changed = 1'b1;
        end
        check("hold_sout", 32'(changed), 32'd0);
        check("hold_busy", 32'(BUSY), 32'd1);
        baud_en = 1'b1;
        wait_idle();

        // BAUDCE coinciding with the acceptance cycle must not count
        baud_en = 1'b0; accept_ce = 1'b1;
        send(8'h96, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        accept_ce = 1'b0; baud_en = 1'b1;
        wait_idle();

        // Asynchronous reset during data bit 3, then a clean character
        send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_frame_start();
        wait_ticks(72);
        #1 RST = 1'b1;
        #1;
        check("arst_sout", 32'(SOUT), 32'd1);
        check("arst_ready", 32'(tx_if.DIN_READY), 32'd1);
        check("arst_busy", 32'(BUSY), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        send(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); wait_idle();

        // Random characters, configurations and baud spacing
        for (int i = 0; i < 12; i++) begin
            baud_div = $urandom_range(2, 5);
            send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
            if (i % 3 == 2) wait_idle();
        end
        wait_idle();

`ifdef UART_TX_BREAK_EN
        begin
            int   ticks, bc_cyc, n;
            logic done;
            baud_div = 4; mon_en = 1'b0; sb_push = 1'b0;
            send(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            ticks = 0; bc_cyc = -10; done = 1'b0; n = 0;
            while (!done && n < 5000) begin
                #1;
                if (n == bc_cyc + 1) check("brk_sout", 32'(SOUT), BC ? 32'd0 : 32'd1);
                if (TXDONE) begin
                    done = 1'b1;
                end else begin
                    if (BAUDCE) ticks++;
                    if (ticks == 40 && !BC && bc_cyc < 0) begin
                        BC = 1'b1; bc_cyc = n;
                    end else if (ticks == 100 && BC) begin
                        BC = 1'b0; bc_cyc = n;
                    end
                    @(negedge CLK);
                    n++;
                end
            end
            check("brk_done_ticks", 32'(ticks), 32'd160);
            @(negedge CLK);
            mon_en = 1'b1; sb_push = 1'b1;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
